// File: rtl/reset_sequencer.sv
// reset_sequencer: filters clock-generator locks and releases staged resets in order.
// Ports: clk_i, rstn_i, locked_i, sw_rst_req_i, stage_rstn_o, all_released_o, lock_loss_cnt_o.
// Macro RST_SEQ_READY_EN adds stage_ready_i, gating each later release on the previous stage.
module reset_sequencer #(
  parameter int NUM_LOCKS   = 3,
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 3,
  parameter int LOCK_FILTER = 8,
  parameter int STAGE_DELAY = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NUM_LOCKS-1:0]  locked_i,
  input  logic                  sw_rst_req_i,
`ifdef RST_SEQ_READY_EN
  input  logic [NUM_STAGES-1:0] stage_ready_i,
`endif
  output logic [NUM_STAGES-1:0] stage_rstn_o,
  output logic                  all_released_o,
  output logic [7:0]            lock_loss_cnt_o
);

  localparam int CMAX =
    (LOCK_FILTER > STAGE_DELAY) ? LOCK_FILTER : STAGE_DELAY;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW =
    (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] LF_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] SD_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST =
    (NUM_STAGES > 1) ? IW'(NUM_STAGES - 2) : '0;

  typedef enum logic [1:0] {
    HOLD,
    FILTER,
    RELEASE,
    RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    all_q, all_d;
  logic [7:0]              loss_q, loss_d;
  logic [NUM_LOCKS-1:0]    sync_q [SYNC_STAGES];
  logic                    all_lk;
  logic                    ready_ok;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= locked_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign all_lk = &sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_READY_EN
  assign ready_ok = stage_ready_i[idx_q];
`else
  assign ready_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    all_d   = all_q;
    loss_d  = loss_q;
    // Abort outranks any release due on the same edge.
    if (state_q != HOLD && (!all_lk || sw_rst_req_i)) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      all_d   = 1'b0;
      if (!all_lk && (state_q == RELEASE || state_q == RUN)
          && loss_q != 8'hff) begin
        loss_d = loss_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        HOLD: begin
          if (all_lk && !sw_rst_req_i) begin
            state_d = FILTER;
            cnt_d   = '0;
          end
        end
        FILTER: begin
          if (cnt_q == LF_LAST) begin
            stage_d[0] = 1'b1;
            cnt_d      = '0;
            idx_d      = '0;
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              all_d   = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt_q != SD_LAST) begin
            cnt_d = cnt_q + CW'(1);
          end else if (ready_ok) begin
            for (int i = 1; i < NUM_STAGES; i++) begin
              if (i == int'(idx_q) + 1) begin
                stage_d[i] = 1'b1;
              end
            end
            idx_d = idx_q + IW'(1);
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              all_d   = 1'b1;
            end
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      all_q   <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      all_q   <= all_d;
      loss_q  <= loss_d;
    end
  end

  assign stage_rstn_o    = stage_q;
  assign all_released_o  = all_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer.
// Model tracks edges since sequence start; monitor compares after each edge.
module tb_reset_sequencer;

  localparam int NL = 3;
  localparam int NS = 3;
  localparam int SY = 3;
  localparam int LF = 8;
  localparam int SD = 16;

  logic          clk;
  logic          rstn_i;
  logic [NL-1:0] locked_i;
  logic          sw_rst_req_i;
  logic [NS-1:0] stage_rstn_o;
  logic          all_released_o;
  logic [7:0]    lock_loss_cnt_o;

  typedef struct {
    logic [NS-1:0] stage;
    logic          all;
    logic [7:0]    loss;
    int            edge_n;
  } exp_t;

  exp_t sbq[$];
  bit   lkq[$];
  int   m_t;
  int   m_loss;
  int   edge_n;
  int   checks;
  int   failures;

  reset_sequencer #(
    .NUM_LOCKS   (NL),
    .NUM_STAGES  (NS),
    .SYNC_STAGES (SY),
    .LOCK_FILTER (LF),
    .STAGE_DELAY (SD)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn_i),
    .locked_i        (locked_i),
    .sw_rst_req_i    (sw_rst_req_i),
`ifdef RST_SEQ_READY_EN
    .stage_ready_i   ({NS{1'b1}}),
`endif
    .stage_rstn_o    (stage_rstn_o),
    .all_released_o  (all_released_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (stage_rstn_o !== e.stage || all_released_o !== e.all
          || lock_loss_cnt_o !== e.loss) begin
        failures++;
        $display("FAIL sb edge=%0d stage=%b/%b all=%b/%b loss=%0d/%0d",
                 e.edge_n, stage_rstn_o, e.stage, all_released_o,
                 e.all, lock_loss_cnt_o, e.loss);
      end
    end
  end

  task automatic dchk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_t    = -1;
    m_loss = 0;
    edge_n = 0;
    lkq.delete();
    repeat (SY) lkq.push_back(1'b0);
  endtask

  // Called at a negedge; drives inputs, predicts the next edge, returns at the next negedge.
  task automatic step(input logic [NL-1:0] lk, input logic sw);
    exp_t e;
    bit   alk;
    locked_i     = lk;
    sw_rst_req_i = sw;
    alk = lkq[0];
    void'(lkq.pop_front());
    lkq.push_back(&lk);
    edge_n++;
    if (m_t < 0) begin
      if (alk && !sw) m_t = 0;
    end else if (!alk || sw) begin
      if (!alk && m_t >= LF && m_loss < 255) m_loss++;
      m_t = -1;
    end else begin
      m_t++;
    end
    for (int k = 0; k < NS; k++) begin
      e.stage[k] = (m_t >= LF + k * SD);
    end
    e.all    = (m_t >= LF + (NS - 1) * SD);
    e.loss   = 8'(m_loss);
    e.edge_n = edge_n;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [NL-1:0] lk);
    @(negedge clk);
    rstn_i       = 1'b0;
    locked_i     = lk;
    sw_rst_req_i = 1'b0;
    repeat (3) @(negedge clk);
    dchk("rst_stage", int'(stage_rstn_o), 0);
    dchk("rst_all", int'(all_released_o), 0);
    dchk("rst_loss", int'(lock_loss_cnt_o), 0);
    model_reset();
    @(negedge clk);
    rstn_i = 1'b1;
  endtask

  initial begin
    int g;
    checks       = 0;
    failures     = 0;
    rstn_i       = 1'b0;
    locked_i     = '0;
    sw_rst_req_i = 1'b0;
    model_reset();

    do_reset(3'b000);
    for (int e = 1; e <= 60; e++) begin
      step(((e - 1) % 10 < 5) ? 3'b111 : 3'b000, 1'b0);
    end
    dchk("toggle_stage", int'(stage_rstn_o), 0);
    dchk("toggle_loss", int'(lock_loss_cnt_o), 0);

    do_reset(3'b111);
    for (int e = 1; e <= 50; e++) begin
      step(3'b111, 1'b0);
      if (e == 11) dchk("lat_e11", int'(stage_rstn_o), 0);
      if (e == 12) dchk("lat_e12", int'(stage_rstn_o), 1);
      if (e == 27) dchk("lat_e27", int'(stage_rstn_o), 1);
      if (e == 28) dchk("lat_e28", int'(stage_rstn_o), 3);
      if (e == 43) dchk("all_e43", int'(all_released_o), 0);
      if (e == 44) dchk("lat_e44", int'(stage_rstn_o), 7);
      if (e == 44) dchk("all_e44", int'(all_released_o), 1);
    end

    do_reset(3'b111);
    for (int e = 1; e <= 80; e++) begin
      step((e == 20) ? 3'b101 : 3'b111, 1'b0);
      if (e == 19) dchk("drop_e19", int'(stage_rstn_o), 1);
      if (e == 24) dchk("drop_e24", int'(stage_rstn_o), 0);
      if (e == 24) dchk("drop_loss", int'(lock_loss_cnt_o), 1);
      if (e == 80) dchk("drop_rerun", int'(stage_rstn_o), 7);
    end

    step(3'b111, 1'b1);
    dchk("sw_stage", int'(stage_rstn_o), 0);
    dchk("sw_loss", int'(lock_loss_cnt_o), 1);
    for (int j = 1; j <= 9; j++) begin
      step(3'b111, 1'b0);
      if (j == 8) dchk("sw_e8", int'(stage_rstn_o), 0);
      if (j == 9) dchk("sw_e9", int'(stage_rstn_o), 1);
    end

    for (int i = 0; i < 300; i++) begin
      g = 0;
      while (m_t < LF && g < 200) begin
        step(3'b111, 1'b0);
        g++;
      end
      step(3'b011, 1'b0);
      repeat (SY) step(3'b111, 1'b0);
    end
    dchk("sat_loss", int'(lock_loss_cnt_o), 255);

    for (int i = 0; i < 3000; i++) begin
      logic [NL-1:0] lk;
      for (int b = 0; b < NL; b++) begin
        lk[b] = ($urandom_range(0, 63) != 0);
      end
      step(lk, $urandom_range(0, 99) == 0);
    end

    step(3'b111, 1'b1);
    g = 0;
    while (m_t != LF + 5 && g < 100) begin
      step(3'b111, 1'b0);
      g++;
    end
    dchk("mid_release", int'(stage_rstn_o), 1);
    #1 rstn_i = 1'b0;
    #1;
    dchk("async_stage", int'(stage_rstn_o), 0);
    dchk("async_all", int'(all_released_o), 0);
    dchk("async_loss", int'(lock_loss_cnt_o), 0);
    model_reset();
    @(negedge clk);
    rstn_i = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step(3'b111, 1'b0);
    end
    dchk("final_stage", int'(stage_rstn_o), 7);

    repeat (2) @(posedge clk);
    #2;
    dchk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
